vga_frame_reader: RTL and testbench
===================================

Name: vga_frame_reader

Overview:
Display back-end of the ASIP. It generates 640x480@60 Hz VGA timing from the 50 MHz system clock and fetches the processed image from the framebuffer RAM through a dedicated read port. It drives the top-level rgb, h_sync, v_sync and vga_clk pins. The image is IMG_W x IMG_H, one 24-bit pixel per address, row-major from BASE_ADDR. It is shown at the top-left of the screen; the rest of the screen is black.

Parameters:
AW, 32, framebuffer address width
BASE_ADDR, 0, address of image pixel (0,0)
IMG_W, 100, image width in pixels (1..H_ACTIVE)
IMG_H, 100, image height in lines (1..V_ACTIVE)
H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels (H_TOTAL = 800)
V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (V_TOTAL = 525)

Ports:
clk  in  1  50 MHz system clock
rst  in  1  synchronous, active-high reset
enable  in  1  display run request, sampled only at frame boundary
mem_addr  out  AW  framebuffer read address
mem_rd_en  out  1  read strobe, high only for in-image pixels
mem_rdata  in  24  read data, valid 1 clk after address/strobe
rgb  out  24  pixel {R[23:16],G[15:8],B[7:0]}
h_sync  out  1  horizontal sync, active low
v_sync  out  1  vertical sync, active low
vga_clk  out  1  25 MHz pixel clock
blank_n  out  1  high during visible area
frame_done  out  1  1-clk pulse at end of each displayed frame

Behaviour:
- Reset, synchronous: state IDLE, phase ph=0, hc=vc=0, row_base=BASE_ADDR.
- Reset output values: rgb=0, h_sync=1, v_sync=1, vga_clk=0, blank_n=0, mem_rd_en=0, mem_addr=BASE_ADDR, frame_done=0.
- Phase and pixel clock: ph toggles every clk. vga_clk = ph. The "pixel tick" is a clk with ph=1. One pixel period = 2 clks.
- Counters: hc 0..799 and vc 0..524 advance only on pixel ticks in RUN. hc wraps to 0 and increments vc. vc wraps to 0 after 524.
- FSM IDLE:
  - Counters held at 0; outputs stay at their reset values.
  - On a pixel tick with enable=1, go to RUN; the first displayed pixel is (0,0).
- FSM RUN:
  - On the pixel tick with hc=799, vc=524: frame_done=1 for that clk.
  - If enable=1 at that tick, continue the next frame seamlessly. Otherwise go to IDLE.
  - Deasserting enable mid-frame has no effect until the frame ends.
- Fetch, for pixel (hc,vc) during its period P:
  - in_img = hc<IMG_W && vc<IMG_H.
  - mem_addr = row_base + hc, stable for both clks of P.
  - mem_rd_en = in_img for both clks.
  - mem_rdata is sampled on the second clk of P.
- Address generation: no multiplier. row_base += IMG_W on the pixel tick ending any line with vc<IMG_H. row_base reloads to BASE_ADDR at frame wrap. Arithmetic is modulo 2^AW.
- Output pipeline: rgb, h_sync, v_sync and blank_n for pixel P are registered and presented during period P+1, all four aligned. Latency is 1 pixel period (2 clks) from address to pin.
  - rgb = mem_rdata if in_img, else 0.
  - blank_n = hc<640 && vc<480.
  - h_sync = 0 iff 656 <= hc <= 751.
  - v_sync = 0 iff 490 <= vc <= 491.
- Boundaries:
  - IMG_W=H_ACTIVE or IMG_H=V_ACTIVE: the full visible area is fetched.
  - The image never fetches during blanking.
  - Reset asserted mid-frame: on the next clk all state and outputs return to reset values, and the next frame starts from (0,0) with row_base=BASE_ADDR.
- Throughput: exactly one read per in-image pixel, never more than one outstanding read. Frame = 840000 clks.

Test Plan:
1. Reset, then enable=1 held -> first pixel tick enters RUN; mem_addr=0 with mem_rd_en=1 for pixel (0,0); rgb of pixel (0,0) appears 2 clks later; vga_clk toggles every clk.
2. Memory model returns rdata = address -> line 0: addresses 0..99 then rd_en=0 for hc>=100; line 1 starts at 100; pixel (99,99) reads 9999; rgb=0 for every pixel outside the image.
3. Sync timing check -> h_sync low for exactly 192 clks per 1600-clk line, starting at hc=656; v_sync low for exactly 2 lines (vc 490-491); blank_n high 640 pixels x 480 lines.
4. enable=1 for 2 frames then dropped mid third frame -> third frame completes; frame_done pulses 3 times, each 840000 clks apart; IDLE afterwards with h_sync=v_sync=1 and rgb=0.
5. enable held 0 after reset -> no mem_rd_en, no frame_done, and outputs stay at reset values for 2M clks.
6. rst pulsed at hc=300, vc=200 -> the next clk shows reset outputs; re-run restarts at address BASE_ADDR for pixel (0,0).

Source files
------------

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - VGA timing generator with framebuffer read-out of a top-left image
module vga_frame_reader #(
  parameter int unsigned     AW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = '0,
  parameter int unsigned     IMG_W     = 100,
  parameter int unsigned     IMG_H     = 100,
  parameter int unsigned     H_ACTIVE  = 640,
  parameter int unsigned     H_FP      = 16,
  parameter int unsigned     H_SYNC    = 96,
  parameter int unsigned     H_BP      = 48,
  parameter int unsigned     V_ACTIVE  = 480,
  parameter int unsigned     V_FP      = 10,
  parameter int unsigned     V_SYNC    = 2,
  parameter int unsigned     V_BP      = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [23:0]   mem_rdata,
  output logic [23:0]   rgb,
  output logic          h_sync,
  output logic          v_sync,
  output logic          vga_clk,
  output logic          blank_n,
  output logic          frame_done
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] HC_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_IMG    = HW'(IMG_W);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VC_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_IMG    = VW'(IMG_H);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          ph;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic [AW-1:0] row_base;

  logic running;
  logic in_row;
  logic in_img;
  logic line_end;
  logic frame_end;

  assign running   = (state == RUN);
  assign in_row    = (vc < V_IMG);
  assign in_img    = (hc < H_IMG) && in_row;
  assign line_end  = running && ph && (hc == HC_LAST);
  assign frame_end = line_end && (vc == VC_LAST);

  // ph alternates every clk; the clk with ph=1 closes the current pixel period
  always_ff @(posedge clk) begin
    if (rst) begin
      ph <= 1'b0;
    end else begin
      ph <= ~ph;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ph && enable) state_nxt = RUN;
      RUN:     if (frame_end && !enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vga_clk    = ph;
    mem_rd_en  = running && in_img;
    mem_addr   = row_base + AW'(hc);
    frame_done = frame_end;
  end

  // row_base tracks the address of column 0 of the current line, avoiding a multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      hc       <= '0;
      vc       <= '0;
      row_base <= BASE_ADDR;
    end else if (running && ph) begin
      if (hc == HC_LAST) begin
        hc <= '0;
        if (vc == VC_LAST) begin
          vc       <= '0;
          row_base <= BASE_ADDR;
        end else begin
          vc <= vc + VW'(1);
          if (in_row) row_base <= row_base + AW'(IMG_W);
        end
      end else begin
        hc <= hc + HW'(1);
      end
    end
  end

  // Pixel outputs are captured on the closing tick so they show during the next period
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb     <= '0;
      h_sync  <= 1'b1;
      v_sync  <= 1'b1;
      blank_n <= 1'b0;
    end else if (ph) begin
      if (running) begin
        rgb     <= in_img ? mem_rdata : 24'h0;
        blank_n <= (hc < H_VIS) && (vc < V_VIS);
        h_sync  <= !((hc >= HS_FIRST) && (hc <= HS_LAST));
        v_sync  <= !((vc >= VS_FIRST) && (vc <= VS_LAST));
      end else begin
        rgb     <= '0;
        h_sync  <= 1'b1;
        v_sync  <= 1'b1;
        blank_n <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - directed bench for vga_frame_reader on a reduced timing grid
module tb_vga_frame_reader;

  localparam int          AW       = 16;
  localparam logic [15:0] BASE     = 16'd1000;
  localparam int          IMG_W    = 4;
  localparam int          IMG_H    = 3;
  localparam int          H_TOTAL  = 15;
  localparam int          V_TOTAL  = 10;
  localparam int          FRAME    = 2 * H_TOTAL * V_TOTAL;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [23:0]   mem_rdata;
  logic [23:0]   rgb;
  logic          h_sync;
  logic          v_sync;
  logic          vga_clk;
  logic          blank_n;
  logic          frame_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fd_count = 0;

  vga_frame_reader #(
    .AW(AW), .BASE_ADDR(BASE), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .rgb(rgb), .h_sync(h_sync), .v_sync(v_sync), .vga_clk(vga_clk),
    .blank_n(blank_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data for a strobed address arrives one clk later
  always @(posedge clk) begin
    mem_rdata <= mem_rd_en ? {8'h5A, mem_addr} : 24'hFFFFFF;
    cyc       <= cyc + 1;
  end

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_img(int h, int v);
    return (h < IMG_W) && (v < IMG_H);
  endfunction

  function automatic logic [31:0] exp_addr(int h, int v);
    int rows;
    rows = (v < IMG_H) ? v : IMG_H;
    return 32'(16'(int'(BASE) + rows * IMG_W + h));
  endfunction

  function automatic logic [31:0] exp_rgb(int h, int v);
    if (!in_img(h, v)) return 32'h0;
    return {8'h00, 8'h5A, exp_addr(h, v)[15:0]};
  endfunction

  function automatic logic [31:0] exp_hs(int h);
    return (h >= 10 && h <= 12) ? 32'd0 : 32'd1;
  endfunction

  function automatic logic [31:0] exp_vs(int v);
    return (v >= 7 && v <= 8) ? 32'd0 : 32'd1;
  endfunction

  function automatic logic [31:0] exp_blank(int h, int v);
    return (h < 8 && v < 6) ? 32'd1 : 32'd0;
  endfunction

  task automatic reset_check(input string p);
    chk({p, ".rgb"},        32'(rgb),        32'h0);
    chk({p, ".h_sync"},     32'(h_sync),     32'd1);
    chk({p, ".v_sync"},     32'(v_sync),     32'd1);
    chk({p, ".vga_clk"},    32'(vga_clk),    32'd0);
    chk({p, ".blank_n"},    32'(blank_n),    32'd0);
    chk({p, ".mem_rd_en"},  32'(mem_rd_en),  32'd0);
    chk({p, ".mem_addr"},   32'(mem_addr),   32'(BASE));
    chk({p, ".frame_done"}, 32'(frame_done), 32'd0);
  endtask

  task automatic enter_run(output int lat);
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (mem_rd_en === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Entered on the first clk of pixel (0,0); walks every pixel period of one frame
  task automatic scan_frame(input string p, input int drop_at, input int stop_at, output int done_cyc);
    int ph_h;
    int ph_v;
    bit last;
    ph_h = H_TOTAL - 1;
    ph_v = V_TOTAL - 1;
    done_cyc = -1;
    for (int v = 0; v < V_TOTAL; v++) begin
      for (int h = 0; h < H_TOTAL; h++) begin
        if (v * H_TOTAL + h == stop_at) return;
        if (v * H_TOTAL + h == drop_at) enable = 1'b0;
        last = (h == H_TOTAL - 1) && (v == V_TOTAL - 1);
        chk($sformatf("%s.vga_clk0(%0d,%0d)", p, h, v), 32'(vga_clk), 32'd0);
        chk($sformatf("%s.rd_en0(%0d,%0d)", p, h, v), 32'(mem_rd_en), 32'(in_img(h, v)));
        chk($sformatf("%s.addr0(%0d,%0d)", p, h, v), 32'(mem_addr), exp_addr(h, v));
        chk($sformatf("%s.rgb(%0d,%0d)", p, ph_h, ph_v), 32'(rgb), exp_rgb(ph_h, ph_v));
        chk($sformatf("%s.hs(%0d,%0d)", p, ph_h, ph_v), 32'(h_sync), exp_hs(ph_h));
        chk($sformatf("%s.vs(%0d,%0d)", p, ph_h, ph_v), 32'(v_sync), exp_vs(ph_v));
        chk($sformatf("%s.blank(%0d,%0d)", p, ph_h, ph_v), 32'(blank_n), exp_blank(ph_h, ph_v));
        chk($sformatf("%s.fd0(%0d,%0d)", p, h, v), 32'(frame_done), 32'd0);
        @(negedge clk);
        chk($sformatf("%s.vga_clk1(%0d,%0d)", p, h, v), 32'(vga_clk), 32'd1);
        chk($sformatf("%s.rd_en1(%0d,%0d)", p, h, v), 32'(mem_rd_en), 32'(in_img(h, v)));
        chk($sformatf("%s.addr1(%0d,%0d)", p, h, v), 32'(mem_addr), exp_addr(h, v));
        chk($sformatf("%s.fd1(%0d,%0d)", p, h, v), 32'(frame_done), 32'(last));
        if (last && frame_done === 1'b1) done_cyc = cyc;
        ph_h = h;
        ph_v = v;
        @(negedge clk);
      end
    end
  endtask

  task automatic idle_watch(input int n, output int rd, output int fd, output int bad);
    rd = 0;
    fd = 0;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mem_rd_en !== 1'b0) rd++;
      if (frame_done !== 1'b0) fd++;
      if (rgb !== 24'h0 || h_sync !== 1'b1 || v_sync !== 1'b1 || blank_n !== 1'b0 || mem_addr !== BASE) bad++;
    end
  endtask

  initial begin
    int lat;
    int t1;
    int t2;
    int t3;
    int t4;
    int rd;
    int fd;
    int bad;

    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset_check("reset");

    rst = 1'b0;
    enable = 1'b1;
    enter_run(lat);
    chk("enter_latency", 32'(lat), 32'd2);

    scan_frame("f1", -1, -1, t1);
    scan_frame("f2", -1, -1, t2);
    scan_frame("f3", 5 * H_TOTAL + 5, -1, t3);
    chk("frame_gap_12", 32'(t2 - t1), 32'(FRAME));
    chk("frame_gap_23", 32'(t3 - t2), 32'(FRAME));
    chk("frame_done_count", 32'(fd_count), 32'd3);

    idle_watch(2 * FRAME, rd, fd, bad);
    chk("after_drop.rd_en_clks", 32'(rd), 32'd0);
    chk("after_drop.frame_done_clks", 32'(fd), 32'd0);
    chk("after_drop.non_reset_clks", 32'(bad), 32'd0);

    enable = 1'b1;
    enter_run(lat);
    chk("rerun_seen", 32'(lat != 0), 32'd1);
    scan_frame("pre_rst", -1, 1 * H_TOTAL + 2, t4);
    rst = 1'b1;
    @(negedge clk);
    reset_check("mid_rst");
    rst = 1'b0;
    enter_run(lat);
    chk("restart_latency", 32'(lat), 32'd2);
    scan_frame("post_rst", 0, -1, t4);
    chk("post_rst_frame_done", 32'(t4 >= 0), 32'd1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fd_count = 0;
    idle_watch(3 * FRAME + 100, rd, fd, bad);
    chk("idle.rd_en_clks", 32'(rd), 32'd0);
    chk("idle.frame_done_clks", 32'(fd), 32'd0);
    chk("idle.non_reset_clks", 32'(bad), 32'd0);
    chk("idle.frame_done_count", 32'(fd_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
